mem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port. Takes one load/store request at a time

---
 rtl/mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Initiator side of the data-memory port. Accepts one load/store request at a
//   time from the datapath, drives address/memWrite/memRead/writeData toward a
//   word-addressed data memory for exactly one cycle, and returns the load data
//   (or store completion) through a valid/ready response channel. Requests that
//   address a word at or beyond MEM_WORDS are rejected without touching memory.
//   Completed loads, completed stores and rejected requests are each counted
//   with saturating counters.
//
// Ports:
//   clock, reset_n          single clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready high only in IDLE)
//   req_write               1 = store, 0 = load
//   req_addr                32-bit word address, compared full-width unsigned
//   req_wdata               store data
//   resp_valid/resp_ready   response handshake
//   resp_data               load data; 0 for stores and rejected requests
//   resp_err                request was out of range, no memory access made
//   address                 memory word address (holds last issued value)
//   memWrite/memRead        one-cycle memory strobes, never both high
//   writeData               memory write data (holds last issued value)
//   readData                memory read data, updated by memory on negedge
//   load_cnt/store_cnt      completed in-range accesses, saturating
//   err_cnt                 rejected requests, saturating
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // request channel
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  // memory side
  output logic [31:0]           address,
  output logic                  memWrite,
  output logic                  memRead,
  output logic [DATA_WIDTH-1:0] writeData,
  input  logic [DATA_WIDTH-1:0] readData,
  // statistics
  output logic [CNT_WIDTH-1:0]  load_cnt,
  output logic [CNT_WIDTH-1:0]  store_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  // First illegal word address, widened to the full request address width so
  // the range check is a plain 32-bit unsigned compare.
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS);

  // Counter slots inside the packed counter vector.
  localparam int CNT_LOAD  = 0;
  localparam int CNT_STORE = 1;
  localparam int CNT_ERR   = 2;
  localparam int NUM_CNT   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched request attributes.
  logic                  write_q,     write_d;
  logic                  resp_err_q,  resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  // Memory-side registers. These only change when an in-range request is
  // accepted, so a rejected request leaves the memory bus quiet and unchanged.
  logic [31:0]           addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;

  logic                  accept;
  logic                  addr_bad;
  logic                  resp_done;
  logic [NUM_CNT-1:0]    cnt_inc;
  logic [NUM_CNT*CNT_WIDTH-1:0] cnt_flat;

  assign accept    = (state_q == IDLE) && req_valid;
  assign addr_bad  = (req_addr >= ADDR_LIMIT);
  assign resp_done = (state_q == RESP) && resp_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Out-of-range requests skip the memory cycle entirely.
          state_d = addr_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // Always exactly one cycle on the memory bus.
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state (plus the registered access type). Because
  // the strobes depend only on flops, an asynchronous reset drops them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    memWrite   = 1'b0;
    memRead    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      ISSUE: begin
        memWrite = write_q;
        memRead  = ~write_q;
      end
      RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    write_d     = write_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    if (accept) begin
      write_d     = req_write;
      resp_err_d  = addr_bad;
      resp_data_d = '0;
      if (!addr_bad) begin
        addr_d = req_addr;
        if (req_write) begin
          wdata_d = req_wdata;
        end
      end
    end else if (state_q == ISSUE) begin
      // The memory presents readData on the mid-cycle negedge, so it is
      // already settled by the posedge that closes ISSUE.
      resp_data_d = write_q ? '0 : readData;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q     <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      write_q     <= write_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign address   = addr_q;
  assign writeData = wdata_q;

  // ---------------------------------------------------------------------------
  // Statistics counters. A transaction is counted on the edge where its
  // response is consumed, so a reset before that edge leaves no trace.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_inc            = '0;
    cnt_inc[CNT_LOAD]  = resp_done && !resp_err_q && !write_q;
    cnt_inc[CNT_STORE] = resp_done && !resp_err_q &&  write_q;
    cnt_inc[CNT_ERR]   = resp_done &&  resp_err_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      // Saturate at all-ones instead of wrapping.
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
  endgenerate

  assign load_cnt  = cnt_flat[CNT_LOAD*CNT_WIDTH  +: CNT_WIDTH];
  assign store_cnt = cnt_flat[CNT_STORE*CNT_WIDTH +: CNT_WIDTH];
  assign err_cnt   = cnt_flat[CNT_ERR*CNT_WIDTH   +: CNT_WIDTH];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl with a behavioural 32-word memory. The
// driver pushes the hand-computed response of each request into a queue; an
// independent monitor pops and compares every consumed response. Counters are
// narrowed to 4 bits so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [31:0]   address;
  logic          memWrite;
  logic          memRead;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData = '0;
  logic [CW-1:0] load_cnt;
  logic [CW-1:0] store_cnt;
  logic [CW-1:0] err_cnt;

  mem_access_ctrl #(
    .DATA_WIDTH(DW),
    .MEM_WORDS (32),
    .CNT_WIDTH (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .address   (address),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .writeData (writeData),
    .readData  (readData),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clock = ~clock;

  // Behavioural memory: write on posedge, read registered on negedge.
  logic [DW-1:0] mem [32] = '{0: 32'd7, 3: 32'd3, 9: 32'd9, default: 32'd0};

  always @(posedge clock) begin
    if (memWrite) mem[address[4:0]] <= writeData;
  end

  always @(negedge clock) begin
    if (memRead) readData <= mem[address[4:0]];
  end

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int mw_cycles = 0;
  int mr_cycles = 0;
  logic [DW:0] exp_q [$];   // {err, data}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every consumed response against the scoreboard and
  // tracks memory strobe activity.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clock);
      if (memWrite) mw_cycles++;
      if (memRead)  mr_cycles++;
      if (memWrite && memRead) check("strobe_mutex", 64'd1, 64'd0);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", 64'(resp_data), 64'(e[DW-1:0]));
          check("resp_err",  64'(resp_err),  64'(e[DW]));
          $display("resp data=0x%08h err=%0d", resp_data, resp_err);
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver helpers (always entered and left at a negedge)
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(req_ready), 64'd1);
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] ed, input logic ee);
    exp_q.push_back({ee, ed});
    wait_idle("wait_ready");
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    if (ee) begin
      check("err_resp_next", 64'(resp_valid), 64'd1);
      check("err_no_strobe", 64'({memWrite, memRead}), 64'd0);
    end else begin
      check("issue_no_resp", 64'(resp_valid), 64'd0);
      check("issue_strobes", 64'({memWrite, memRead}), 64'({w, ~w}));
      check("issue_addr",    64'(address), 64'(a));
      @(negedge clock);
      check("resp_latency",  64'(resp_valid), 64'd1);
      check("resp_strobes",  64'({memWrite, memRead}), 64'd0);
    end
    $display("req write=%0d addr=0x%08h wdata=0x%08h", w, a, d);
    @(negedge clock);
    wait_idle("return_idle");
  endtask

  int exp_load  = 0;
  int exp_store = 0;
  int exp_err   = 0;

  task automatic check_cnts(input string name);
    check({name, "_load"},  64'(load_cnt),  64'(exp_load));
    check({name, "_store"}, 64'(store_cnt), 64'(exp_store));
    check({name, "_err"},   64'(err_cnt),   64'(exp_err));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int mw0, mr0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_req_ready",  64'(req_ready), 64'd1);
    check("rst_outputs",    64'({resp_valid, resp_err, memWrite, memRead}), 64'd0);
    check("rst_buses",      64'({address, resp_data}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1: reset in the middle of a store's ISSUE cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd9; req_wdata = 32'hDEADBEEF;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("t1_in_issue", 64'(memWrite), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t1_memwrite_drop", 64'(memWrite), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t1_mem_unchanged", 64'(mem[9]), 64'd9);
    check("t1_req_ready", 64'(req_ready), 64'd1);
    check("t1_resp_valid", 64'(resp_valid), 64'd0);
    check_cnts("t1_cnt");
    $display("reset during store issue addr=9");

    // 2: store then load of the same word.
    mw0 = mw_cycles;
    do_req(1'b1, 32'd5, 32'hA5A5A5A5, 32'd0, 1'b0);
    exp_store++;
    check("t2_memwrite_cycles", 64'(mw_cycles - mw0), 64'd1);
    check("t2_mem_written", 64'(mem[5]), 64'hA5A5A5A5);
    mr0 = mr_cycles;
    do_req(1'b0, 32'd5, 32'd0, 32'hA5A5A5A5, 1'b0);
    exp_load++;
    check("t2_memread_cycles", 64'(mr_cycles - mr0), 64'd1);
    check_cnts("t2_cnt");

    // 3: loads from preloaded words.
    do_req(1'b0, 32'd0, 32'd0, 32'd7, 1'b0);
    do_req(1'b0, 32'd3, 32'd0, 32'd3, 1'b0);
    exp_load += 2;
    check_cnts("t3_cnt");

    // 4: out-of-range requests never touch memory.
    mw0 = mw_cycles;
    mr0 = mr_cycles;
    do_req(1'b0, 32'd32,       32'd0,        32'd0, 1'b1);
    do_req(1'b1, 32'hFFFFFFFF, 32'h12345678, 32'd0, 1'b1);
    exp_err += 2;
    check("t4_no_strobes", 64'((mw_cycles - mw0) + (mr_cycles - mr0)), 64'd0);
    check_cnts("t4_cnt");

    // 5: response back-pressure with an ignored request pulse.
    resp_ready = 1'b0;
    mw0 = mw_cycles;
    exp_q.push_back({1'b0, 32'd3});
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd3;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 64'(resp_valid), 64'd1);
      check("t5_hold_data",  64'(resp_data),  64'd3);
      check("t5_hold_err",   64'(resp_err),   64'd0);
      check("t5_hold_ready", 64'(req_ready),  64'd0);
      req_valid = (i == 2);
      req_write = 1'b1;
      req_addr  = 32'd7;
      req_wdata = 32'hCAFEF00D;
      @(negedge clock);
    end
    req_valid = 1'b0;
    @(posedge clock);
    #1 resp_ready = 1'b1;
    @(negedge clock);
    wait_idle("t5_idle");
    exp_load++;
    repeat (3) @(negedge clock);
    check("t5_no_extra_resp", 64'(resp_valid), 64'd0);
    check("t5_pulse_ignored", 64'(mw_cycles - mw0), 64'd0);
    check("t5_mem7", 64'(mem[7]), 64'd0);
    check_cnts("t5_cnt");
    $display("backpressure load addr=3 held 5 cycles");

    // 6: bring store_cnt to all-ones minus 1, then 3 more stores saturate it.
    for (int i = 0; i < 13; i++) begin
      do_req(1'b1, 32'(i + 10), 32'(i), 32'd0, 1'b0);
      exp_store++;
    end
    check("t6_store_pre", 64'(store_cnt), 64'd14);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 32'd31, 32'(i), 32'd0, 1'b0);
      exp_store = (exp_store < 15) ? exp_store + 1 : 15;
    end
    check("t6_store_sat", 64'(store_cnt), 64'd15);
    check_cnts("t6_cnt");

    repeat (3) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
